// File: rtl/alu_dispatch_sequencer.sv
// Sequences one ALU operation: opcode/src1/src2 bus phases, then waits for the
// selected unit's valid (bounded by TIMEOUT) and reports Done or Error.
module alu_dispatch_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [7:0]   Opcode,
  input  logic [255:0] Src1,
  input  logic [255:0] Src2,
  input  logic [255:0] IntAluDataOut,
  input  logic [255:0] MatAluDataOut,
  input  logic         IntValid,
  input  logic         MatValid,
  output logic [255:0] BusData,
  output logic         opcodeonBus,
  output logic         src1onBus,
  output logic         src2onBus,
  output logic         destonBus,
  output logic         UnitSel,
  output logic         Busy,
  output logic         Done,
  output logic         Error,
  output logic [255:0] Result
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_SRC1, S_SRC2, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   opc_q, opc_d;
  logic [255:0] src1_q, src1_d;
  logic [255:0] src2_q, src2_d;
  logic         unit_q, unit_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [255:0] result_q, result_d;
  logic         sel_vld;

  assign UnitSel = unit_q;
  assign Result  = result_q;
  assign sel_vld = unit_q ? IntValid : MatValid;

  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    unit_d      = unit_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    BusData     = '0;
    opcodeonBus = 1'b0;
    src1onBus   = 1'b0;
    src2onBus   = 1'b0;
    destonBus   = 1'b0;
    Done        = 1'b0;
    Error       = 1'b0;
    Busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          opc_d   = Opcode;
          src1_d  = Src1;
          src2_d  = Src2;
          unit_d  = Opcode[7];
          state_d = S_OPC;
        end
      end
      S_OPC: begin
        BusData     = {248'b0, opc_q};
        opcodeonBus = 1'b1;
        state_d     = S_SRC1;
      end
      S_SRC1: begin
        BusData   = src1_q;
        src1onBus = 1'b1;
        state_d   = S_SRC2;
      end
      S_SRC2: begin
        BusData   = src2_q;
        src2onBus = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        destonBus = 1'b1;
        // valid is checked before the timeout so a coincident valid still completes
        if (sel_vld) begin
          result_d = unit_q ? IntAluDataOut : MatAluDataOut;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        Error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      unit_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      unit_q   <= unit_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_dispatch_sequencer.sv
// Scoreboard bench: each issued op pushes its expected outcome and completion
// cycle; a negedge monitor pops on Done/Error and compares.
module tb_alu_dispatch_sequencer;
  localparam int TO = 16;

  logic         Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [7:0]   Opcode = '0;
  logic [255:0] Src1 = '0, Src2 = '0, IntAluDataOut = '0, MatAluDataOut = '0;
  logic         IntValid = 1'b0, MatValid = 1'b0;
  logic [255:0] BusData, Result;
  logic         opcodeonBus, src1onBus, src2onBus, destonBus;
  logic         UnitSel, Busy, Done, Error;

  alu_dispatch_sequencer #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
    .Src1(Src1), .Src2(Src2),
    .IntAluDataOut(IntAluDataOut), .MatAluDataOut(MatAluDataOut),
    .IntValid(IntValid), .MatValid(MatValid),
    .BusData(BusData), .opcodeonBus(opcodeonBus), .src1onBus(src1onBus),
    .src2onBus(src2onBus), .destonBus(destonBus), .UnitSel(UnitSel),
    .Busy(Busy), .Done(Done), .Error(Error), .Result(Result)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit           err;
    logic [255:0] res;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0, failures = 0;
  logic [255:0] cur_res = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    chk("strobe_onehot", 256'($countones({opcodeonBus, src1onBus, src2onBus, destonBus}) <= 1), 256'd1);
    if (Done || Error) begin
      if (sb_q.size() == 0) chk("spurious_pulse", {Done, Error}, 2'b00);
      else begin
        e = sb_q.pop_front();
        chk("pulse_kind", {Done, Error}, e.err ? 2'b01 : 2'b10);
        chk("result", Result, e.res);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // n = WAIT cycle (1-based) carrying the selected valid; 0 = never -> timeout
  task automatic do_op(input logic [7:0] op, input logic [255:0] s1, input logic [255:0] s2,
                       input logic [255:0] d, input int n, input bit other_hi, input bit keep_start);
    logic u;
    int   acc, waits;
    u = op[7];
    waits = (n == 0) ? TO : n;
    @(negedge Clk);
    chk("idle_busy", Busy, 0);
    Start = 1'b1; Opcode = op; Src1 = s1; Src2 = s2; acc = cyc;
    if (u) begin IntAluDataOut = d; MatAluDataOut = ~d; MatValid = other_hi; end
    else   begin MatAluDataOut = d; IntAluDataOut = ~d; IntValid = other_hi; end
    sb_q.push_back('{err: (n == 0), res: (n == 0) ? cur_res : d, cyc: acc + 4 + waits});
    if (n != 0) cur_res = d;
    @(negedge Clk);
    Start = keep_start; Opcode = ~op; Src1 = ~s1; Src2 = ~s2;
    chk("opc_strobe", {opcodeonBus, Busy, UnitSel}, {2'b11, u});
    chk("opc_bus", BusData, {248'b0, op});
    @(negedge Clk);
    chk("src1_strobe", {src1onBus, Busy}, 2'b11);
    chk("src1_bus", BusData, s1);
    @(negedge Clk);
    chk("src2_strobe", {src2onBus, Busy}, 2'b11);
    chk("src2_bus", BusData, s2);
    for (int k = 1; k <= waits; k++) begin
      @(negedge Clk);
      chk("wait_dest", {destonBus, Busy, Done, Error}, 4'b1100);
      chk("wait_bus", BusData, 0);
      if (u) IntValid = (k == n); else MatValid = (k == n);
    end
    @(negedge Clk);
    IntValid = 1'b0; MatValid = 1'b0;
    chk("end_busy", Busy, 1);
  endtask

  initial begin
    // reset has priority over a concurrent Start
    Start = 1'b1; Opcode = 8'h81;
    repeat (2) @(negedge Clk);
    chk("rst_bus", BusData, 0);
    chk("rst_res", Result, 0);
    chk("rst_ctl", {opcodeonBus, src1onBus, src2onBus, destonBus, UnitSel, Busy, Done, Error}, 0);
    Reset = 1'b0; Start = 1'b0;

    do_op(8'h81, 256'd5, 256'd7, 256'd12, 2, 1'b0, 1'b0);
    do_op(8'h02, {8{32'hA5A5_0001}}, {8{32'h5A5A_0002}}, {8{32'h1234_5678}}, 1, 1'b1, 1'b0);
    do_op(8'h83, 256'd1, 256'd2, 256'hDEAD, 0, 1'b0, 1'b0);
    do_op(8'h10, 256'd3, 256'd4, 256'hBEEF, TO, 1'b1, 1'b0);
    // Start held high: exactly one op, the next accepted on the following IDLE
    do_op(8'hC4, 256'd9, 256'd10, 256'hCAFE, 3, 1'b0, 1'b1);
    do_op(8'h44, 256'd11, 256'd12, 256'hF00D, 4, 1'b0, 1'b0);

    // reset during SRC2 abandons the op without any pulse
    @(negedge Clk);
    Start = 1'b1; Opcode = 8'h85; Src1 = 256'd21; Src2 = 256'd22;
    @(negedge Clk); Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("pre_rst_src2", src2onBus, 1);
    Reset = 1'b1; IntValid = 1'b1; IntAluDataOut = 256'd99;
    @(negedge Clk);
    Reset = 1'b0; IntValid = 1'b0; cur_res = '0;
    chk("midrst_bus", BusData, 0);
    chk("midrst_res", Result, 0);
    chk("midrst_ctl", {opcodeonBus, src1onBus, src2onBus, destonBus, UnitSel, Busy, Done, Error}, 0);
    do_op(8'h86, 256'd31, 256'd32, 256'd77, 1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++)
      do_op(8'($urandom), {8{$urandom}}, {8{$urandom}}, {8{$urandom}},
            $urandom_range(0, TO), 1'($urandom), 1'b0);

    repeat (3) @(negedge Clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
